// File: rtl/gpr_bank_snap_pkg.sv
// Shared definitions for the register bank with BRAM snapshot/restore:
// default geometry, transfer FSM encoding and the byte-per-word derivation.
package gpr_bank_snap_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DUMP     = 2'd1,
      ST_RST_RD   = 2'd2,
      ST_RST_WAIT = 2'd3
   } state_t;

   function automatic int bytes_per_word(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/gpr_bank_snap_if.sv
// BRAM port bundle: master is the register bank's transfer engine, slave is the memory.
interface gpr_bank_snap_if
   import gpr_bank_snap_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int BRAM_AW = 32
);
   logic                  bram_clk;
   logic                  bram_rst;
   logic                  bram_en;
   logic [DATA_W/8-1:0]   bram_we;
   logic [BRAM_AW-1:0]    bram_addr;
   logic [DATA_W-1:0]     bram_wdata;
   logic [DATA_W-1:0]     bram_rdata;

   modport master (
      output bram_clk, bram_rst, bram_en, bram_we, bram_addr, bram_wdata,
      input  bram_rdata
   );

   modport slave (
      input  bram_clk, bram_rst, bram_en, bram_we, bram_addr, bram_wdata,
      output bram_rdata
   );
endinterface

// File: rtl/gpr_snap_ctrl.sv
// Snapshot/restore sequencer: request edge detection, transfer FSM, index/wait
// counters and BRAM port drive. Hands dump index and restore writes to the bank.
module gpr_snap_ctrl
   import gpr_bank_snap_pkg::*;
#(
   parameter int          DATA_W    = DEF_DATA_W,
   parameter int          ADDR_W    = DEF_ADDR_W,
   parameter int          BRAM_AW   = 32,
   parameter int unsigned BASE_ADDR = 0,
   parameter int          RD_LAT    = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_snap_req,
   input  logic              i_restore_req,
   output logic              o_busy,
   output logic              o_done,
   output logic [ADDR_W-1:0] o_dump_idx,
   input  logic [DATA_W-1:0] i_dump_data,
   output logic              o_rst_we,
   output logic [ADDR_W-1:0] o_rst_idx,
   output logic [DATA_W-1:0] o_rst_data,
   gpr_bank_snap_if.master   bram
);
   localparam int              BPW       = bytes_per_word(DATA_W);
   localparam int              DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W + 1)'(DEPTH - 1);
   localparam logic [1:0]      WAIT_LAST = 2'(RD_LAT - 1);

   logic               r_snap_q0, r_snap_q1, r_rest_q0, r_rest_q1;
   state_t             r_state, w_next;
   logic [ADDR_W:0]    r_idx;
   logic [1:0]         r_wait;
   logic               r_done;
   logic               w_snap_pulse, w_rest_pulse, w_idx_last, w_wait_last;
   logic [BRAM_AW-1:0] w_addr;

   assign w_snap_pulse = r_snap_q0 & ~r_snap_q1;
   assign w_rest_pulse = r_rest_q0 & ~r_rest_q1;
   assign w_idx_last   = (r_idx == LAST_IDX);
   assign w_wait_last  = (r_wait == WAIT_LAST);
   assign w_addr       = BRAM_AW'(BASE_ADDR) + BRAM_AW'(r_idx) * BRAM_AW'(BPW);
   assign o_dump_idx   = r_idx[ADDR_W-1:0];
   assign o_rst_idx    = r_idx[ADDR_W-1:0];
   assign o_rst_data   = bram.bram_rdata;
   assign o_done       = r_done;

   // Detector flops reset high so a request level held through reset never fires.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         {r_snap_q0, r_snap_q1, r_rest_q0, r_rest_q1} <= 4'b1111;
      end else begin
         r_snap_q0 <= i_snap_req;
         r_snap_q1 <= r_snap_q0;
         r_rest_q0 <= i_restore_req;
         r_rest_q1 <= r_rest_q0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_idx   <= {(ADDR_W + 1){1'b0}};
         r_wait  <= 2'd0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= (r_state != ST_IDLE) && (w_next == ST_IDLE);
         case (r_state)
            ST_DUMP: begin
               r_idx <= (w_next == ST_IDLE) ? {(ADDR_W + 1){1'b0}} : r_idx + 1'b1;
            end
            ST_RST_RD: begin
               r_wait <= 2'd0;
            end
            ST_RST_WAIT: begin
               if (w_wait_last) begin
                  r_wait <= 2'd0;
                  r_idx  <= (w_next == ST_IDLE) ? {(ADDR_W + 1){1'b0}} : r_idx + 1'b1;
               end else begin
                  r_wait <= r_wait + 2'd1;
               end
            end
            default: begin
               r_idx  <= {(ADDR_W + 1){1'b0}};
               r_wait <= 2'd0;
            end
         endcase
      end
   end

   // Snapshot has priority when both pulses land in the same IDLE cycle.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_snap_pulse)      w_next = ST_DUMP;
            else if (w_rest_pulse) w_next = ST_RST_RD;
            else                   w_next = ST_IDLE;
         end
         ST_DUMP: begin
            if (w_idx_last) w_next = ST_IDLE;
            else            w_next = ST_DUMP;
         end
         ST_RST_RD:   w_next = ST_RST_WAIT;
         ST_RST_WAIT: begin
            if (w_wait_last && w_idx_last) w_next = ST_IDLE;
            else if (w_wait_last)          w_next = ST_RST_RD;
            else                           w_next = ST_RST_WAIT;
         end
         default:     w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      bram.bram_en    = 1'b0;
      bram.bram_we    = {BPW{1'b0}};
      bram.bram_addr  = {BRAM_AW{1'b0}};
      bram.bram_wdata = {DATA_W{1'b0}};
      o_rst_we        = 1'b0;
      o_busy          = (r_state != ST_IDLE);
      case (r_state)
         ST_DUMP: begin
            bram.bram_en    = 1'b1;
            bram.bram_we    = {BPW{1'b1}};
            bram.bram_addr  = w_addr;
            bram.bram_wdata = i_dump_data;
         end
         ST_RST_RD: begin
            bram.bram_en   = 1'b1;
            bram.bram_addr = w_addr;
         end
         ST_RST_WAIT: begin
            bram.bram_addr = w_addr;
            o_rst_we       = w_wait_last;
         end
         default: begin
            o_rst_we = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/gpr_bank_snap.sv
// ID-stage register file: two combinational read ports, one write port, and a
// BRAM snapshot/restore engine that stalls the pipeline via o_busy.
module gpr_bank_snap
   import gpr_bank_snap_pkg::*;
#(
   parameter int          DATA_W    = DEF_DATA_W,
   parameter int          ADDR_W    = DEF_ADDR_W,
   parameter int          BRAM_AW   = 32,
   parameter int unsigned BASE_ADDR = 0,
   parameter int          RD_LAT    = 1,
   parameter bit          BYPASS    = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [ADDR_W-1:0] i_rd_addr_a,
   input  logic [ADDR_W-1:0] i_rd_addr_b,
   output logic [DATA_W-1:0] o_rd_data_a,
   output logic [DATA_W-1:0] o_rd_data_b,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_wr_en,
   input  logic              i_snap_req,
   input  logic              i_restore_req,
   output logic              o_busy,
   output logic              o_done,
   gpr_bank_snap_if.master   bram
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_regs [DEPTH];
   logic              w_busy, w_core_we, w_rst_we;
   logic [ADDR_W-1:0] w_dump_idx, w_rst_idx;
   logic [DATA_W-1:0] w_rst_data;
   logic [ADDR_W-1:0] w_rd_addr [2];
   logic [DATA_W-1:0] w_rd_data [2];

   assign bram.bram_clk = i_clk;
   assign bram.bram_rst = i_rst;
   assign o_busy        = w_busy;
   assign w_core_we     = i_wr_en & ~w_busy & (i_wr_addr != {ADDR_W{1'b0}});
   assign w_rd_addr[0]  = i_rd_addr_a;
   assign w_rd_addr[1]  = i_rd_addr_b;
   assign o_rd_data_a   = w_rd_data[0];
   assign o_rd_data_b   = w_rd_data[1];

   gpr_snap_ctrl #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .BRAM_AW   (BRAM_AW),
      .BASE_ADDR (BASE_ADDR),
      .RD_LAT    (RD_LAT)
   ) u_ctrl (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_snap_req    (i_snap_req),
      .i_restore_req (i_restore_req),
      .o_busy        (w_busy),
      .o_done        (o_done),
      .o_dump_idx    (w_dump_idx),
      .i_dump_data   (r_regs[w_dump_idx]),
      .o_rst_we      (w_rst_we),
      .o_rst_idx     (w_rst_idx),
      .o_rst_data    (w_rst_data),
      .bram          (bram)
   );

   // Entry 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) r_regs[i] <= {DATA_W{1'b0}};
      end else if (w_core_we) begin
         r_regs[i_wr_addr] <= i_wr_data;
      end else if (w_rst_we && (w_rst_idx != {ADDR_W{1'b0}})) begin
         r_regs[w_rst_idx] <= w_rst_data;
      end
   end

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         if (w_rd_addr[p] == {ADDR_W{1'b0}})
            w_rd_data[p] = {DATA_W{1'b0}};
         else if (BYPASS && w_core_we && (i_wr_addr == w_rd_addr[p]))
            w_rd_data[p] = i_wr_data;
         else
            w_rd_data[p] = r_regs[w_rd_addr[p]];
      end
   end

endmodule
